// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    localparam int AW_DEF   = 11;
    localparam int OFFW_DEF = 8;
    localparam int CNT_W    = 16;

    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // Next-PC source chosen by the sequencer FSM.
    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_SEQ  = 2'd1,
        SEL_ABS  = 2'd2,
        SEL_REL  = 2'd3
    } pc_sel_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Control/fetch bundle between the top level, decode/execute and the fetch sequencer.
interface fetch_sequencer_if #(
    parameter int AW   = fetch_pkg::AW_DEF,
    parameter int OFFW = fetch_pkg::OFFW_DEF
);
    import fetch_pkg::*;

    // Start is a level request taken whenever the sequencer is not in RUN; stall is the
    // ready-low of the execute stage and freezes RUN, so branch/halt requests must be held
    // until an edge with stall=0 consumes them. inst_valid marks inst_address as executable.
    logic             Start;
    logic [AW-1:0]    start_addr;
    logic             stall;
    logic             br_taken;
    logic             br_rel;
    logic [AW-1:0]    br_target;
    logic [OFFW-1:0]  br_offset;
    logic             halt_req;
    logic [AW-1:0]    inst_address;
    logic             inst_valid;
    logic             Done;
    logic [CNT_W-1:0] inst_count;
    fetch_state_t     state_dbg;

    modport master (
        input  Start, start_addr, stall, br_taken, br_rel, br_target, br_offset, halt_req,
        output inst_address, inst_valid, Done, inst_count, state_dbg
    );

    modport slave (
        output Start, start_addr, stall, br_taken, br_rel, br_target, br_offset, halt_req,
        input  inst_address, inst_valid, Done, inst_count, state_dbg
    );

endinterface

// File: rtl/fetch_sequencer_pc_next.sv
// Combinational next-PC selection: hold, sequential, absolute or relative branch (modulo 2**AW).
module pc_next
    import fetch_pkg::*;
#(
    parameter int AW   = AW_DEF,
    parameter int OFFW = OFFW_DEF
) (
    input  logic [AW-1:0]   pc,
    input  pc_sel_t         sel,
    input  logic [AW-1:0]   br_target,
    input  logic [OFFW-1:0] br_offset,
    output logic [AW-1:0]   pc_nxt
);

    logic [AW-1:0] off_ext;

    assign off_ext = {{(AW-OFFW){br_offset[OFFW-1]}}, br_offset};

    always_comb begin
        pc_nxt = pc;
        case (sel)
            SEL_SEQ:  pc_nxt = pc + AW'(1);
            SEL_ABS:  pc_nxt = br_target;
            SEL_REL:  pc_nxt = pc + off_ext;
            default:  pc_nxt = pc;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and IDLE/RUN/HALT fetch FSM driving the instruction ROM address.
// The fetch counter is built only when FETCH_INST_CNT_EN is defined; otherwise inst_count is 0.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int OFFW     = OFFW_DEF,
    parameter int RESET_PC = 0
) (
    input  logic               Clk,
    input  logic               Reset_n,
    fetch_sequencer_if.master  bus
);

    fetch_state_t  state, state_nxt;
    pc_sel_t       sel;
    logic          load_start;
    logic [AW-1:0] pc, pc_adv, pc_d;

    pc_next #(.AW(AW), .OFFW(OFFW)) u_pc_next (
        .pc        (pc),
        .sel       (sel),
        .br_target (bus.br_target),
        .br_offset (bus.br_offset),
        .pc_nxt    (pc_adv)
    );

    // Halt outranks any branch presented in the same cycle; stall freezes only RUN.
    always_comb begin
        state_nxt  = state;
        sel        = SEL_HOLD;
        load_start = 1'b0;
        case (state)
            IDLE, HALT: begin
                if (bus.Start) begin
                    load_start = 1'b1;
                    state_nxt  = RUN;
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    if (bus.halt_req)    state_nxt = HALT;
                    else if (bus.br_taken) sel = bus.br_rel ? SEL_REL : SEL_ABS;
                    else                 sel = SEL_SEQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pc_d = load_start ? bus.start_addr : pc_adv;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            pc    <= AW'(RESET_PC);
        end else begin
            state <= state_nxt;
            pc    <= pc_d;
        end
    end

    assign bus.inst_address = pc;
    assign bus.inst_valid   = (state == RUN);
    assign bus.Done         = (state == HALT);
    assign bus.state_dbg    = state;

`ifdef FETCH_INST_CNT_EN
    logic [CNT_W-1:0] cnt;
    logic             cnt_step;

    // Every unstalled RUN edge counts, including the one that accepts a halt.
    assign cnt_step = (state == RUN) && !bus.stall;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)                         cnt <= '0;
        else if (load_start)                  cnt <= '0;
        else if (cnt_step && cnt != CNT_SAT)  cnt <= cnt + CNT_W'(1);
    end

    assign bus.inst_count = cnt;
`else
    assign bus.inst_count = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed fetch scenarios followed by random traffic.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    localparam int AW    = 11;
    localparam int OFFW  = 8;
    localparam int DEPTH = 1 << AW;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fetch_sequencer_if #(.AW(AW), .OFFW(OFFW)) bus ();

    fetch_sequencer #(.AW(AW), .OFFW(OFFW), .RESET_PC(0)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus.master)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference model: program state in plain integers
    int m_pc;
    bit m_run;
    bit m_done;
    int m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit start, input int saddr, input bit stl, input bit br,
                         input bit rel, input int tgt, input int off, input bit halt);
        bus.Start      = start;
        bus.start_addr = AW'(saddr);
        bus.stall      = stl;
        bus.br_taken   = br;
        bus.br_rel     = rel;
        bus.br_target  = AW'(tgt);
        bus.br_offset  = OFFW'(off);
        bus.halt_req   = halt;
    endtask

    task automatic model_reset();
        m_pc   = 0;
        m_run  = 1'b0;
        m_done = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic model_edge();
        int off;
        off = int'($signed(bus.br_offset));
        if (!m_run) begin
            if (bus.Start) begin
                m_pc   = int'(bus.start_addr);
                m_run  = 1'b1;
                m_done = 1'b0;
                m_cnt  = 0;
            end
        end else if (!bus.stall) begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (bus.halt_req) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end else if (bus.br_taken && !bus.br_rel) begin
                m_pc = int'(bus.br_target);
            end else if (bus.br_taken) begin
                m_pc = ((m_pc + off) % DEPTH + DEPTH) % DEPTH;
            end else begin
                m_pc = (m_pc + 1) % DEPTH;
            end
        end
    endtask

    task automatic check_outputs();
        check("inst_address", 32'(bus.inst_address), 32'(m_pc));
        check("inst_valid",   32'(bus.inst_valid),   32'(m_run));
        check("done",         32'(bus.Done),         32'(m_done));
`ifdef FETCH_INST_CNT_EN
        check("inst_count",   32'(bus.inst_count),   32'(m_cnt));
`else
        check("inst_count",   32'(bus.inst_count),   32'd0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    // asynchronous reset pulse landing between clock edges
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #1 rst_n = 1'b0;
        #11;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // start at 0 and run sequentially
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("start_valid", 32'(bus.inst_valid), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) tick();
        check("seq_addr5", 32'(bus.inst_address), 32'd5);

        // absolute and relative branches with wrap
        drive(0, 0, 0, 1, 0, 10, 0, 0);   tick();
        drive(0, 0, 0, 1, 0, 300, 0, 0);  tick();
        check("abs_300", 32'(bus.inst_address), 32'd300);
        drive(0, 0, 0, 1, 1, 0, -5, 0);   tick();
        check("rel_295", 32'(bus.inst_address), 32'd295);
        drive(0, 0, 0, 1, 0, 3, 0, 0);    tick();
        drive(0, 0, 0, 1, 1, 0, -5, 0);   tick();
        check("rel_wrap_2046", 32'(bus.inst_address), 32'd2046);
        drive(0, 0, 0, 0, 0, 0, 0, 0);    tick();
        tick();
        check("seq_wrap_0", 32'(bus.inst_address), 32'd0);

        // stall holds a pending branch
        drive(0, 0, 0, 1, 0, 20, 0, 0);   tick();
        drive(1, 33, 1, 1, 0, 900, 0, 1);
        repeat (3) tick();
        check("stall_hold_20", 32'(bus.inst_address), 32'd20);
        drive(0, 0, 0, 1, 0, 900, 0, 0);  tick();
        check("stall_release", 32'(bus.inst_address), 32'd900);

        // halt beats branch; restart from HALT during a stall
        drive(0, 0, 0, 1, 0, 7, 0, 0);    tick();
        drive(0, 0, 0, 1, 0, 500, 0, 1);  tick();
        check("halt_done", 32'(bus.Done), 32'd1);
        check("halt_addr", 32'(bus.inst_address), 32'd7);
        drive(0, 0, 0, 0, 0, 0, 0, 0);    tick();
        drive(1, 100, 1, 0, 0, 0, 0, 0);  tick();
        check("restart_100", 32'(bus.inst_address), 32'd100);
        check("restart_done", 32'(bus.Done), 32'd0);

        // asynchronous reset mid-run at PC 50
        drive(0, 0, 0, 1, 0, 50, 0, 0);   tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        async_reset();
        check("reset_addr", 32'(bus.inst_address), 32'd0);
        tick();
        tick();
        check("idle_no_start", 32'(bus.inst_valid), 32'd0);

        // counter: 6 unstalled, 2 stalled, then halt
        drive(1, 0, 0, 0, 0, 0, 0, 0);    tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (6) tick();
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        repeat (2) tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1);    tick();
`ifdef FETCH_INST_CNT_EN
        check("count_7", 32'(bus.inst_count), 32'd7);
`else
        check("count_off", 32'(bus.inst_count), 32'd0);
`endif

        // random traffic
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 9) == 0, int'($urandom_range(0, DEPTH - 1)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, DEPTH - 1)),
                  int'($urandom_range(0, 255)) - 128, $urandom_range(0, 24) == 0);
            tick();
            if ($urandom_range(0, 99) == 0) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
